// File: rtl/aes_round_key_sequencer_if.sv
// Key-load / round-key stream bundle between the key source, the sequencer and the round core.
// master = key source and round-key consumer side; slave = aes_round_key_sequencer.
interface aes_round_key_sequencer_if #(
  parameter int RK_W = 128
);
  logic            key_load;
  logic [RK_W-1:0] key;
  logic            key_ready;
  logic            busy;
  logic            stream_start;
  logic            dir;
  logic            rk_valid;
  logic            rk_ready;
  logic [RK_W-1:0] rk_out;
  logic [3:0]      rk_round;
  logic            stream_done;

  modport master (
    output key_load, key, stream_start, dir, rk_ready,
    input  key_ready, busy, rk_valid, rk_out, rk_round, stream_done
  );

  modport slave (
    input  key_load, key, stream_start, dir, rk_ready,
    output key_ready, busy, rk_valid, rk_out, rk_round, stream_done
  );
endinterface

// File: rtl/aes_round_key_sequencer.sv
// AES-128 key expansion into an 11-entry round-key store, streamed out enc (0..10) or dec (10..0).
// Expansion: one round per cycle, key_ready 11 cycles after key_load. Stream: registered, stalls on !rk_ready. Optional macro: RK_CACHE_EN.
module aes_round_key_sequencer #(
  parameter int NR   = 10,
  parameter int RK_W = 128
) (
  input logic                    CLK,
  input logic                    rst,
  aes_round_key_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_EXPAND = 2'd1;
  localparam logic [1:0] S_READY  = 2'd2;
  localparam logic [1:0] S_STREAM = 2'd3;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // Word w0 sits in the top 32 bits, matching the cipher-key layout.
  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = sub_word(rot_word(k[31:0])) ^ {rc, 24'h000000};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [1:0]      r_state;
  logic [3:0]      r_cnt;
  logic [RK_W-1:0] r_store [0:NR];
  logic            r_dir;
  logic            r_rk_vld;
  logic [RK_W-1:0] r_rk_out;
  logic [3:0]      r_rk_round;
  logic            r_done;

  logic [RK_W-1:0] w_prev;
  logic [RK_W-1:0] w_next;
  logic [3:0]      w_idx_nxt;
  logic            w_last;
  logic            w_reload;

  assign w_prev    = r_store[r_cnt - 4'd1];
  assign w_next    = key_next(w_prev, rcon(r_cnt));
  assign w_idx_nxt = r_dir ? (r_rk_round - 4'd1) : (r_rk_round + 4'd1);
  assign w_last    = r_dir ? (r_rk_round == 4'd0) : (r_rk_round == 4'(NR));

`ifdef RK_CACHE_EN
  // Reloading the key already expanded leaves the schedule and key_ready untouched.
  assign w_reload = bus.key_load && (bus.key != r_store[0]);
`else
  assign w_reload = bus.key_load;
`endif

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_dir      <= 1'b0;
      r_rk_vld   <= 1'b0;
      r_rk_out   <= '0;
      r_rk_round <= 4'd0;
      r_done     <= 1'b0;
      for (int i = 0; i <= NR; i++) begin
        r_store[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.key_load) begin
            r_store[0] <= bus.key;
            r_cnt      <= 4'd1;
            r_state    <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          r_store[r_cnt] <= w_next;
          r_cnt          <= r_cnt + 4'd1;
          if (r_cnt == 4'(NR)) begin
            r_state <= S_READY;
          end
        end
        S_READY: begin
          // A key_load always shadows a coincident stream_start.
          if (bus.key_load) begin
            if (w_reload) begin
              r_store[0] <= bus.key;
              r_cnt      <= 4'd1;
              r_state    <= S_EXPAND;
            end
          end else if (bus.stream_start) begin
            r_dir      <= bus.dir;
            r_rk_round <= bus.dir ? 4'(NR) : 4'd0;
            r_rk_out   <= bus.dir ? r_store[NR] : r_store[0];
            r_rk_vld   <= 1'b1;
            r_state    <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (bus.rk_ready) begin
            if (w_last) begin
              r_rk_vld   <= 1'b0;
              r_rk_out   <= '0;
              r_rk_round <= 4'd0;
              r_done     <= 1'b1;
              r_state    <= S_READY;
            end else begin
              r_rk_round <= w_idx_nxt;
              r_rk_out   <= r_store[w_idx_nxt];
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.key_ready   = (r_state == S_READY);
  assign bus.busy        = (r_state == S_EXPAND) || (r_state == S_STREAM);
  assign bus.rk_valid    = r_rk_vld;
  assign bus.rk_out      = r_rk_out;
  assign bus.rk_round    = r_rk_round;
  assign bus.stream_done = r_done;

endmodule
